// File: rtl/pcntr.sv
`timescale 1ns/1ps
// pcntr -- parameterised up/down pulse counter.
//
// Counts enabled count events (level or rising-edge qualified) up or down,
// either wrapping or saturating at the range limits, and reports each
// boundary hit with a one-cycle pulse and a sticky flag.
//
// Parameters
//   W     counter width in bits (2..32)
//   SAT   0 = wrap at boundary, 1 = saturate (hold) at boundary
//   EDGE  0 = one count per enabled cycle with i_in high,
//         1 = one count per rising edge of i_in
//
// Ports
//   i_clk       clock, all state changes on its rising edge
//   i_rst_n     asynchronous active-low reset
//   i_in        count request
//   i_en        count enable
//   i_dir       1 = count up, 0 = count down
//   i_ld        synchronous load strobe (overrides counting)
//   i_ld_val    load value
//   i_clr_flw   clears the sticky boundary flag (a new boundary wins)
//   o_out       registered count value
//   o_flw       registered one-cycle boundary pulse
//   o_flw_stky  registered sticky boundary flag
//   o_zero      high whenever o_out is zero
module pcntr #(
  parameter int W    = 4,
  parameter int SAT  = 0,
  parameter int EDGE = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in,
  input  logic         i_en,
  input  logic         i_dir,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_clr_flw,
  output logic [W-1:0] o_out,
  output logic         o_flw,
  output logic         o_flw_stky,
  output logic         o_zero
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic         in_q;
  logic         cev;
  logic         at_bound;
  logic         bnd;
  logic [W-1:0] cnt_nxt;
  logic         stky_nxt;

  // Count event qualification: level mode or rising-edge mode.
  always_comb begin
    cev = 1'b0;
    if (EDGE != 0) begin
      cev = i_en & i_in & ~in_q;
    end else begin
      cev = i_en & i_in;
    end
  end

  // Next count value and boundary detection; load overrides any count event.
  always_comb begin
    at_bound = 1'b0;
    bnd      = 1'b0;
    cnt_nxt  = o_out;
    if (i_dir) begin
      at_bound = (o_out == CNT_MAX);
    end else begin
      at_bound = (o_out == CNT_ZERO);
    end
    if (i_ld) begin
      cnt_nxt = i_ld_val;
      bnd     = 1'b0;
    end else if (cev) begin
      bnd = at_bound;
      if (at_bound && (SAT != 0)) begin
        cnt_nxt = o_out;
      end else if (i_dir) begin
        // modulo-2^W add gives the 2^W-1 -> 0 wrap for free
        cnt_nxt = o_out + CNT_ONE;
      end else begin
        // modulo-2^W subtract gives the 0 -> 2^W-1 wrap for free
        cnt_nxt = o_out - CNT_ONE;
      end
    end else begin
      cnt_nxt = o_out;
      bnd     = 1'b0;
    end
  end

  // Sticky flag: a boundary in the same cycle beats a clear request.
  always_comb begin
    stky_nxt = o_flw_stky;
    if (bnd) begin
      stky_nxt = 1'b1;
    end else if (i_clr_flw) begin
      stky_nxt = 1'b0;
    end else begin
      stky_nxt = o_flw_stky;
    end
  end

  // State registers: input history, count, and boundary flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_q       <= 1'b0;
      o_out      <= CNT_ZERO;
      o_flw      <= 1'b0;
      o_flw_stky <= 1'b0;
    end else begin
      in_q       <= i_in;
      o_out      <= cnt_nxt;
      o_flw      <= bnd;
      o_flw_stky <= stky_nxt;
    end
  end

  // Zero decode of the count register.
  assign o_zero = (o_out == CNT_ZERO);

endmodule

// File: tb/tb_pcntr.sv
`timescale 1ns/1ps
// Self-checking bench for pcntr. Three instances (wrap/level, saturate/level,
// wrap/edge) share one stimulus stream; an arithmetic reference model tracks
// each, and directed expectations cover the documented scenarios.
module tb_pcntr;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         din   = 1'b0;
  logic         en    = 1'b0;
  logic         dir   = 1'b0;
  logic         ld    = 1'b0;
  logic [W-1:0] ld_val = '0;
  logic         clr   = 1'b0;

  logic [W-1:0] out0, out1, out2;
  logic         flw0, flw1, flw2;
  logic         stk0, stk1, stk2;
  logic         zro0, zro1, zro2;

  logic [W-1:0] d_out [3];
  logic         d_flw [3];
  logic         d_stk [3];
  logic         d_zro [3];

  assign d_out[0] = out0; assign d_out[1] = out1; assign d_out[2] = out2;
  assign d_flw[0] = flw0; assign d_flw[1] = flw1; assign d_flw[2] = flw2;
  assign d_stk[0] = stk0; assign d_stk[1] = stk1; assign d_stk[2] = stk2;
  assign d_zro[0] = zro0; assign d_zro[1] = zro1; assign d_zro[2] = zro2;

  pcntr #(.W(W), .SAT(0), .EDGE(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(din), .i_en(en), .i_dir(dir),
    .i_ld(ld), .i_ld_val(ld_val), .i_clr_flw(clr),
    .o_out(out0), .o_flw(flw0), .o_flw_stky(stk0), .o_zero(zro0));

  pcntr #(.W(W), .SAT(1), .EDGE(0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(din), .i_en(en), .i_dir(dir),
    .i_ld(ld), .i_ld_val(ld_val), .i_clr_flw(clr),
    .o_out(out1), .o_flw(flw1), .o_flw_stky(stk1), .o_zero(zro1));

  pcntr #(.W(W), .SAT(0), .EDGE(1)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(din), .i_en(en), .i_dir(dir),
    .i_ld(ld), .i_ld_val(ld_val), .i_clr_flw(clr),
    .o_out(out2), .o_flw(flw2), .o_flw_stky(stk2), .o_zero(zro2));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state, one slot per instance
  int sat_cfg  [3] = '{0, 1, 0};
  int edge_cfg [3] = '{0, 0, 1};
  int m_cnt [3];
  bit m_flw [3];
  bit m_stk [3];
  bit m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = 0;
      m_flw[c] = 1'b0;
      m_stk[c] = 1'b0;
    end
    m_prev = 1'b0;
  endfunction

  // One clock of the specified behaviour, using the currently driven inputs.
  function automatic void model_step();
    for (int c = 0; c < 3; c++) begin
      bit ev;
      bit hit;
      int nxt;
      ev  = en && din && (edge_cfg[c] == 0 || !m_prev);
      hit = 1'b0;
      if (ld) begin
        m_cnt[c] = int'(ld_val);
      end else if (ev) begin
        nxt = m_cnt[c] + (dir ? 1 : -1);
        if (nxt < 0 || nxt > MAXV) begin
          hit = 1'b1;
          if (sat_cfg[c] == 0) m_cnt[c] = (nxt + MAXV + 1) % (MAXV + 1);
        end else begin
          m_cnt[c] = nxt;
        end
      end
      m_flw[c] = hit;
      if (hit) m_stk[c] = 1'b1;
      else if (clr) m_stk[c] = 1'b0;
    end
    m_prev = din;
  endfunction

  task automatic chk_model();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("u%0d.out", c), 32'(d_out[c]), 32'(m_cnt[c]));
      chk($sformatf("u%0d.flw", c), 32'(d_flw[c]), 32'(m_flw[c]));
      chk($sformatf("u%0d.stky", c), 32'(d_stk[c]), 32'(m_stk[c]));
      chk($sformatf("u%0d.zero", c), 32'(d_zro[c]), 32'(m_cnt[c] == 0));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  // Assert reset away from any clock edge and check outputs clear without a clock.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst.u%0d.out", c), 32'(d_out[c]), 32'd0);
      chk($sformatf("rst.u%0d.flw", c), 32'(d_flw[c]), 32'd0);
      chk($sformatf("rst.u%0d.stky", c), 32'(d_stk[c]), 32'd0);
      chk($sformatf("rst.u%0d.zero", c), 32'(d_zro[c]), 32'd1);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    #3;
    reset_pulse();
  endtask

  initial begin
    model_reset();
    #1;
    reset_pulse();

    // Free-running up count: wrap vs saturate vs edge-qualified.
    en = 1'b1; din = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("s1.u0.out", 32'(out0), 32'(k % 16));
      chk("s1.u0.flw", 32'(flw0), 32'(k == 16));
      chk("s1.u1.out", 32'(out1), 32'((k < 15) ? k : 15));
      chk("s1.u1.flw", 32'(flw1), 32'(k >= 16));
      chk("s1.u2.out", 32'(out2), 32'd1);
    end
    chk("s1.u0.stky", 32'(stk0), 32'd1);
    chk("s1.u1.stky", 32'(stk1), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr.u1.stky_setwins", 32'(stk1), 32'd1);
    chk("clr.u1.flw", 32'(flw1), 32'd1);
    chk("clr.u0.stky", 32'(stk0), 32'd0);
    chk("clr.u0.out", 32'(out0), 32'd5);

    // Edge counting: 10 rising edges, then a long high level.
    do_reset();
    en = 1'b1; dir = 1'b1;
    for (int r = 0; r < 10; r++) begin
      din = 1'b1; tick(); tick();
      din = 1'b0; tick(); tick();
    end
    chk("edge.u2.out10", 32'(out2), 32'd10);
    chk("edge.u0.out", 32'(out0), 32'd4);
    chk("edge.u1.out", 32'(out1), 32'd15);
    din = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("edge.u2.out11", 32'(out2), 32'd11);
    chk("edge.u0.out9", 32'(out0), 32'd9);

    // Disabled: nothing moves.
    en = 1'b0; din = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("dis.u0.out", 32'(out0), 32'd9);
      chk("dis.u1.out", 32'(out1), 32'd15);
      chk("dis.u2.out", 32'(out2), 32'd11);
      chk("dis.u0.flw", 32'(flw0), 32'd0);
      chk("dis.u1.flw", 32'(flw1), 32'd0);
    end

    // Load, count down through zero, and load beating a boundary event.
    do_reset();
    en = 1'b1; din = 1'b1; dir = 1'b0;
    ld = 1'b1; ld_val = 4'd3;
    tick();
    ld = 1'b0;
    chk("dn.u0.load3", 32'(out0), 32'd3);
    tick(); chk("dn.u0.2", 32'(out0), 32'd2);
    tick(); chk("dn.u0.1", 32'(out0), 32'd1);
    tick(); chk("dn.u0.0", 32'(out0), 32'd0);
    chk("dn.u0.zero", 32'(zro0), 32'd1);
    tick(); chk("dn.u0.wrap15", 32'(out0), 32'd15);
    chk("dn.u0.flw", 32'(flw0), 32'd1);
    chk("dn.u1.hold0", 32'(out1), 32'd0);
    ld = 1'b1; ld_val = 4'd0;
    tick();
    chk("ldb.u0.out_pre", 32'(out0), 32'd0);
    tick();
    ld = 1'b0;
    chk("ldb.u0.out", 32'(out0), 32'd0);
    chk("ldb.u0.flw", 32'(flw0), 32'd0);
    chk("ldb.u0.stky", 32'(stk0), 32'd1);
    chk("ldb.u1.flw", 32'(flw1), 32'd0);

    // Asynchronous reset mid-count, then restart from zero.
    do_reset();
    en = 1'b1; din = 1'b1; dir = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    chk("ar.u0.out9", 32'(out0), 32'd9);
    do_reset();
    tick(); chk("ar.u0.restart1", 32'(out0), 32'd1);
    chk("ar.u2.count_once", 32'(out2), 32'd1);
    tick(); chk("ar.u0.restart2", 32'(out0), 32'd2);
    chk("ar.u2.hold", 32'(out2), 32'd1);

    // Randomised traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      if (k % 24 == 0) dir = 1'($urandom_range(0, 1));
      din    = 1'($urandom_range(0, 1));
      en     = ($urandom_range(0, 3) != 0);
      ld     = ($urandom_range(0, 19) == 0);
      ld_val = 4'($urandom_range(0, MAXV));
      clr    = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
